lab4_mcore_dual_port_mem_responder: RTL and testbench
=====================================================

Name: lab4_mcore_dual_port_mem_responder

Overview:
Memory-side responder for one core's imem/dmem 16B request ports, i.e. the far end of the caches' refill/evict traffic.
- Accepts mem_req_16B_t on two val/rdy request ports.
- Arbitrates round-robin into one line-wide storage array.
- Returns mem_resp_16B_t on the matching response port after a fixed pipeline latency.
- Used as main memory in single-core simulation and as a reusable backing store behind the caches.

Parameters:
- p_num_lines, 256: storage depth in 16B lines; power of two, 2..4096.
- p_latency, 2: cycles from request acceptance to earliest response valid; integer >= 1.
- p_resp_depth, 2: per-port response-queue entries, which is also the per-port credit count; integer >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- imemreq_msg  in  mem_req_16B_t  instruction-side request
- imemreq_val  in  1  request valid
- imemreq_rdy  out  1  request accepted this cycle
- imemresp_msg  out  mem_resp_16B_t  instruction-side response
- imemresp_val  out  1  response valid
- imemresp_rdy  in  1  consumer ready
- dmemreq_msg / dmemreq_val / dmemreq_rdy: same as the imem request group, data side
- dmemresp_msg / dmemresp_val / dmemresp_rdy: same as the imem response group, data side
- num_reads  out  32  count of accepted reads, both ports
- num_writes  out  32  count of accepted writes and inits, both ports

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high.
- While reset is asserted:
  - all rdy/val outputs are 0;
  - pipeline and queues are emptied;
  - credits are set to p_resp_depth;
  - the round-robin pointer is set to imem;
  - num_reads and num_writes are 0.
  - Storage contents are not reset.
  - Reset asserted mid-transaction discards all in-flight requests and responses. No response for them ever appears.
- Request indexing and length:
  - Line index = addr[3+log2(p_num_lines):4]. Upper address bits are ignored, so addresses alias modulo the array size.
  - len=0 selects the full 16B line.
  - len=4 selects the 32-bit word at line offset addr[3:2].
  - Any other len is a simulation error ($error); hardware treats it as len=0.
- Request types:
  - read (0): response data = the line (len=0), or the word zero-extended into data[31:0] (len=4).
  - write (1) and init (2): update storage; response data = 0.
  - Other types: simulation error; no storage update; response data = 0.
- Response fields:
  - type, opaque and len are echoed from the request.
  - test = 2'b00.
- Eligibility and arbitration:
  - A port is eligible when its val=1 and its credit > 0.
  - At most one grant per cycle.
  - If both ports are eligible, the port named by the round-robin pointer wins. The pointer then moves to the other port; it moves only on a grant.
  - req_rdy = grant. rdy depends combinationally on val and credit.
- Storage timing:
  - The storage read or write happens in the acceptance cycle t.
  - A read accepted at t+1 observes a write accepted at t.
- Latency pipeline:
  - The accepted response (msg + port id) enters a p_latency-stage shift register.
  - On exit it is pushed into that port's FIFO queue.
  - If the queue is empty, resp_val rises exactly in cycle t+p_latency. Otherwise the response waits behind earlier ones.
  - Per-port responses are in order. Cross-port order is unconstrained.
- Credit counting:
  - The credit counter per port is clog2(p_resp_depth+1) bits.
  - It decrements on accept and increments on resp_val & resp_rdy; when both happen in the same cycle it is unchanged.
  - Credits bound in-flight + queued responses, so the pipeline never stalls and queues never overflow. Overflow or underflow is an assertion failure.
- Full and empty:
  - Credit = 0 forces that port's req_rdy = 0; the other port is unaffected.
  - An empty queue gives resp_val = 0.
- A stalled resp_rdy blocks only its own port's queue.

Optional Feature:
Macro LAB4_MCORE_MEM_RESPONDER_STATS_EN.
- Defined:
  - num_reads increments by 1 on every accepted read.
  - num_writes increments by 1 on every accepted write or init.
  - Both wrap at 2^32.
- Undefined:
  - both outputs are tied to 0;
  - no counter flops are synthesized.
- Ports exist in both builds.

Decomposition:
- Message structs come from the existing shared mem-msgs package.
- Add to it request/response type constants (READ=0, WRITE=1, INIT=2) and field-width localparams.
- One sub-module: lab4_mcore_mem_resp_queue, a parameterised mem_resp_16B_t FIFO with enq/deq val/rdy and an async active-high reset. It is instantiated once per port.
- Arbiter, pipeline, credits and storage stay in the top module.

Test Plan:
- Reset then idle: all val/rdy are 0 during reset. After reset, a dmem read with no req_val gives no response and counters stay 0.
- Init then read, p_latency=2: dmem init addr 0x1000, len 0, data 0x0123..CDEF, accepted at cycle t → dmemresp type 2, data 0 at t+2. Then a dmem read of 0x1000 → data 0x0123..CDEF, opaque echoed, test 00.
- Word write/read: write len=4, addr 0x1008, data 0xDEADBEEF → read len=0 of 0x1000 returns the line with bits[95:64] = 0xDEADBEEF. A len=4 read of 0x1008 returns 0x000..DEADBEEF.
- Arbitration: both ports hold val=1 for 4 cycles from reset → grants alternate imem, dmem, imem, dmem; each port receives its own opaque values in order.
- Backpressure: dmemresp_rdy=0, p_resp_depth=2, dmem sends 3 reads → 2 accepted, dmemreq_rdy=0 afterwards, imem traffic still served. Raising dmemresp_rdy drains 2 responses, then the third request is accepted.
- Reset mid-flight: reset asserted one cycle after accepting an imem read → no imemresp_val ever appears. After reset, credits are full and a new read completes in p_latency cycles.

Source files
------------

// File: rtl/lab4_mcore_dual_port_mem_responder_pkg.sv
`default_nettype none
// lab4_mcore_dual_port_mem_responder_pkg: 16B memory message structs, type codes and field widths. Rev 1.0
package lab4_mcore_dual_port_mem_responder_pkg;

  localparam int c_type_w   = 3;
  localparam int c_opaque_w = 8;
  localparam int c_addr_w   = 32;
  localparam int c_len_w    = 4;
  localparam int c_data_w   = 128;
  localparam int c_test_w   = 2;

  localparam logic [c_type_w-1:0] c_type_read  = 3'd0;
  localparam logic [c_type_w-1:0] c_type_write = 3'd1;
  localparam logic [c_type_w-1:0] c_type_init  = 3'd2;

  typedef struct packed {
    logic [c_type_w-1:0]   msg_type;
    logic [c_opaque_w-1:0] opaque;
    logic [c_addr_w-1:0]   addr;
    logic [c_len_w-1:0]    len;
    logic [c_data_w-1:0]   data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [c_type_w-1:0]   msg_type;
    logic [c_opaque_w-1:0] opaque;
    logic [c_test_w-1:0]   test;
    logic [c_len_w-1:0]    len;
    logic [c_data_w-1:0]   data;
  } mem_resp_16B_t;

  function automatic logic is_store_type(input logic [c_type_w-1:0] t);
    return (t == c_type_write) || (t == c_type_init);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lab4_mcore_mem_resp_queue.sv
`default_nettype none
// lab4_mcore_mem_resp_queue: registered-output FIFO of mem_resp_16B_t with val/rdy on both sides. Rev 1.0
module lab4_mcore_mem_resp_queue
  import lab4_mcore_dual_port_mem_responder_pkg::*;
#(
  parameter int p_depth = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enq_val,
  output logic          enq_rdy,
  input  mem_resp_16B_t enq_msg,
  output logic          deq_val,
  input  logic          deq_rdy,
  output mem_resp_16B_t deq_msg
);

  localparam int c_ptr_w = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int c_cnt_w = $clog2(p_depth + 1);

  mem_resp_16B_t        entries [p_depth];
  logic [c_ptr_w-1:0]   wr_ptr;
  logic [c_ptr_w-1:0]   rd_ptr;
  logic [c_cnt_w-1:0]   count;
  logic                 enq;
  logic                 deq;

  assign enq_rdy = (count != c_cnt_w'(p_depth));
  assign deq_val = (count != '0);
  assign deq_msg = entries[rd_ptr];
  assign enq     = enq_val && enq_rdy;
  assign deq     = deq_val && deq_rdy;

  always_ff @(posedge clk) begin
    if (enq) entries[wr_ptr] <= enq_msg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= (wr_ptr == c_ptr_w'(p_depth - 1)) ? '0 : wr_ptr + 1'b1;
      if (deq) rd_ptr <= (rd_ptr == c_ptr_w'(p_depth - 1)) ? '0 : rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/lab4_mcore_dual_port_mem_responder.sv
`default_nettype none
// lab4_mcore_dual_port_mem_responder: imem/dmem 16B-line backing store, round-robin, fixed latency. Rev 1.0
// Define LAB4_MCORE_MEM_RESPONDER_STATS_EN to enable the num_reads/num_writes counters.
module lab4_mcore_dual_port_mem_responder
  import lab4_mcore_dual_port_mem_responder_pkg::*;
#(
  parameter int p_num_lines  = 256,
  parameter int p_latency    = 2,
  parameter int p_resp_depth = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  mem_req_16B_t  imemreq_msg,
  input  logic          imemreq_val,
  output logic          imemreq_rdy,
  output mem_resp_16B_t imemresp_msg,
  output logic          imemresp_val,
  input  logic          imemresp_rdy,
  input  mem_req_16B_t  dmemreq_msg,
  input  logic          dmemreq_val,
  output logic          dmemreq_rdy,
  output mem_resp_16B_t dmemresp_msg,
  output logic          dmemresp_val,
  input  logic          dmemresp_rdy,
  output logic [31:0]   num_reads,
  output logic [31:0]   num_writes
);

  localparam int c_idx_w  = $clog2(p_num_lines);
  localparam int c_cred_w = $clog2(p_resp_depth + 1);

  logic [c_cred_w-1:0] icredit, dcredit;
  logic                rr_dmem;
  logic                ielig, delig, igrant, dgrant, accept;
  logic                ideq, ddeq, iq_enq_rdy, dq_enq_rdy;
  mem_req_16B_t        req;
  mem_resp_16B_t       resp_msg;
  logic [127:0]        mem [p_num_lines];
  logic [c_idx_w-1:0]  idx;
  logic [1:0]          off;
  logic                word_sel;
  logic [127:0]        line;
  logic [31:0]         word;
  logic                unused_addr;

  // Credits reserve a queue slot at acceptance, so the pipeline itself never stalls.
  assign ielig  = imemreq_val && (icredit != '0);
  assign delig  = dmemreq_val && (dcredit != '0);
  assign igrant = !reset && ielig && (!delig || !rr_dmem);
  assign dgrant = !reset && delig && (!ielig || rr_dmem);
  assign accept = igrant || dgrant;
  assign imemreq_rdy = igrant;
  assign dmemreq_rdy = dgrant;
  assign ideq = imemresp_val && imemresp_rdy;
  assign ddeq = dmemresp_val && dmemresp_rdy;

  assign req         = dgrant ? dmemreq_msg : imemreq_msg;
  assign idx         = req.addr[3+c_idx_w:4];
  assign off         = req.addr[3:2];
  assign word_sel    = (req.len == 4'd4);
  assign line        = mem[idx];
  assign word        = line[{off, 5'b0} +: 32];
  assign unused_addr = ^req.addr;

  always_comb begin
    resp_msg          = '0;
    resp_msg.msg_type = req.msg_type;
    resp_msg.opaque   = req.opaque;
    resp_msg.len      = req.len;
    resp_msg.test     = 2'b00;
    if (req.msg_type == c_type_read) resp_msg.data = word_sel ? {96'b0, word} : line;
  end

  always_ff @(posedge clk) begin
    if (accept && is_store_type(req.msg_type)) begin
      if (word_sel) mem[idx][{off, 5'b0} +: 32] <= req.data[31:0];
      else          mem[idx] <= req.data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_dmem <= 1'b0;
      icredit <= c_cred_w'(p_resp_depth);
      dcredit <= c_cred_w'(p_resp_depth);
    end else begin
      if (igrant)      rr_dmem <= 1'b1;
      else if (dgrant) rr_dmem <= 1'b0;
      case ({igrant, ideq})
        2'b10:   icredit <= icredit - 1'b1;
        2'b01:   icredit <= icredit + 1'b1;
        default: icredit <= icredit;
      endcase
      case ({dgrant, ddeq})
        2'b10:   dcredit <= dcredit - 1'b1;
        2'b01:   dcredit <= dcredit + 1'b1;
        default: dcredit <= dcredit;
      endcase
    end
  end

  // Stage 0 is the acceptance cycle itself; the queue's registered output adds the last cycle.
  logic          exit_val;
  logic          exit_port;
  mem_resp_16B_t exit_msg;

  generate
    if (p_latency == 1) begin : g_no_pipe
      assign exit_val  = accept;
      assign exit_port = dgrant;
      assign exit_msg  = resp_msg;
    end else begin : g_pipe
      logic          stage_val  [p_latency-1];
      logic          stage_port [p_latency-1];
      mem_resp_16B_t stage_msg  [p_latency-1];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < p_latency - 1; k++) begin
            stage_val[k]  <= 1'b0;
            stage_port[k] <= 1'b0;
            stage_msg[k]  <= '0;
          end
        end else begin
          stage_val[0]  <= accept;
          stage_port[0] <= dgrant;
          stage_msg[0]  <= resp_msg;
          for (int k = 1; k < p_latency - 1; k++) begin
            stage_val[k]  <= stage_val[k-1];
            stage_port[k] <= stage_port[k-1];
            stage_msg[k]  <= stage_msg[k-1];
          end
        end
      end
      assign exit_val  = stage_val[p_latency-2];
      assign exit_port = stage_port[p_latency-2];
      assign exit_msg  = stage_msg[p_latency-2];
    end
  endgenerate

  lab4_mcore_mem_resp_queue #(.p_depth(p_resp_depth)) imem_q (
    .clk(clk), .reset(reset),
    .enq_val(exit_val && !exit_port), .enq_rdy(iq_enq_rdy), .enq_msg(exit_msg),
    .deq_val(imemresp_val), .deq_rdy(imemresp_rdy), .deq_msg(imemresp_msg)
  );

  lab4_mcore_mem_resp_queue #(.p_depth(p_resp_depth)) dmem_q (
    .clk(clk), .reset(reset),
    .enq_val(exit_val && exit_port), .enq_rdy(dq_enq_rdy), .enq_msg(exit_msg),
    .deq_val(dmemresp_val), .deq_rdy(dmemresp_rdy), .deq_msg(dmemresp_msg)
  );

`ifdef LAB4_MCORE_MEM_RESPONDER_STATS_EN
  logic [31:0] read_cnt, write_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_cnt  <= '0;
      write_cnt <= '0;
    end else if (accept) begin
      if (req.msg_type == c_type_read)  read_cnt  <= read_cnt + 32'd1;
      if (is_store_type(req.msg_type)) write_cnt <= write_cnt + 32'd1;
    end
  end
  assign num_reads  = read_cnt;
  assign num_writes = write_cnt;
`else
  assign num_reads  = '0;
  assign num_writes = '0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      if (accept && !(req.len == 4'd0 || req.len == 4'd4)) $error("unsupported len %0d", req.len);
      if (accept && req.msg_type > c_type_init) $error("unsupported type %0d", req.msg_type);
      assert (!(ideq && !igrant && icredit == c_cred_w'(p_resp_depth))) else $error("imem credit overflow");
      assert (!(ddeq && !dgrant && dcredit == c_cred_w'(p_resp_depth))) else $error("dmem credit overflow");
      assert (!(exit_val && !exit_port && !iq_enq_rdy)) else $error("imem queue overflow");
      assert (!(exit_val && exit_port && !dq_enq_rdy)) else $error("dmem queue overflow");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lab4_mcore_dual_port_mem_responder.sv
`default_nettype none
// tb_lab4_mcore_dual_port_mem_responder: directed vector table plus multi-cycle sequences.
module tb_lab4_mcore_dual_port_mem_responder;
  import lab4_mcore_dual_port_mem_responder_pkg::*;

  logic clk, reset;
  mem_req_16B_t  imemreq_msg, dmemreq_msg;
  mem_resp_16B_t imemresp_msg, dmemresp_msg;
  logic imemreq_val, imemreq_rdy, imemresp_val, imemresp_rdy;
  logic dmemreq_val, dmemreq_rdy, dmemresp_val, dmemresp_rdy;
  logic [31:0] num_reads, num_writes;

  lab4_mcore_dual_port_mem_responder dut (
    .clk(clk), .reset(reset),
    .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy),
    .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
    .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy),
    .num_reads(num_reads), .num_writes(num_writes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         dport;
    logic [2:0]   typ;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
    logic [7:0]   opq;
    logic [127:0] exp_data;
  } vec_t;

  localparam logic [127:0] LINE  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] LINE2 = 128'h01234567DEADBEEF0123456789ABCDEF;
  localparam logic [127:0] LINE3 = 128'hCAFEF00D112233445566778899AABBCC;

  int checks = 0;
  int passes = 0;
  int exp_reads = 0;
  int exp_writes = 0;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic mem_req_16B_t mk_req(input logic [2:0] t, input logic [31:0] a,
                                          input logic [3:0] l, input logic [127:0] d,
                                          input logic [7:0] o);
    mem_req_16B_t m;
    m.msg_type = t; m.addr = a; m.len = l; m.data = d; m.opaque = o;
    return m;
  endfunction

  task automatic drive(input logic dport, input logic val, input mem_req_16B_t m);
    if (dport) begin dmemreq_val = val; dmemreq_msg = m; end
    else       begin imemreq_val = val; imemreq_msg = m; end
  endtask

  task automatic count_req(input logic [2:0] t);
    if (t == 3'd0) exp_reads++;
    else exp_writes++;
  endtask

  task automatic check_counters(input string name);
`ifdef LAB4_MCORE_MEM_RESPONDER_STATS_EN
    chk({name, "_reads"}, 128'(num_reads), 128'(exp_reads));
    chk({name, "_writes"}, 128'(num_writes), 128'(exp_writes));
`else
    chk({name, "_reads"}, 128'(num_reads), 128'd0);
    chk({name, "_writes"}, 128'(num_writes), 128'd0);
`endif
  endtask

  // Issue one request on an idle port and check acceptance, latency and every response field.
  task automatic run_vec(input string nm, input vec_t v);
    mem_req_16B_t  m;
    mem_resp_16B_t r;
    m = mk_req(v.typ, v.addr, v.len, v.data, v.opq);
    drive(v.dport, 1'b1, m);
    @(negedge clk);
    chk({nm, "_rdy"}, 128'(v.dport ? dmemreq_rdy : imemreq_rdy), 128'd1);
    @(posedge clk); #1;
    drive(v.dport, 1'b0, m);
    count_req(v.typ);
    @(negedge clk);
    chk({nm, "_early"}, 128'(v.dport ? dmemresp_val : imemresp_val), 128'd0);
    @(posedge clk);
    @(negedge clk);
    r = v.dport ? dmemresp_msg : imemresp_msg;
    chk({nm, "_val"}, 128'(v.dport ? dmemresp_val : imemresp_val), 128'd1);
    chk({nm, "_type"}, 128'(r.msg_type), 128'(v.typ));
    chk({nm, "_opq"}, 128'(r.opaque), 128'(v.opq));
    chk({nm, "_len"}, 128'(r.len), 128'(v.len));
    chk({nm, "_test"}, 128'(r.test), 128'd0);
    chk({nm, "_data"}, r.data, v.exp_data);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_reads = 0;
    exp_writes = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ilog [$];
    logic [7:0] dlog [$];
    int         icyc [$];
    int         dcyc [$];
    logic [7:0] iop, dop;
    logic       igr [4];

    vecs[0] = '{1'b1, 3'd2, 32'h0000_1000, 4'd0, LINE, 8'h01, 128'h0};
    vecs[1] = '{1'b1, 3'd0, 32'h0000_1000, 4'd0, 128'h0, 8'h02, LINE};
    vecs[2] = '{1'b1, 3'd1, 32'h0000_1008, 4'd4, 128'h11111111222222223333333_3DEADBEEF, 8'h03, 128'h0};
    vecs[3] = '{1'b1, 3'd0, 32'h0000_1000, 4'd0, 128'h0, 8'h04, LINE2};
    vecs[4] = '{1'b1, 3'd0, 32'h0000_1008, 4'd4, 128'h0, 8'h05, 128'hDEADBEEF};
    vecs[5] = '{1'b0, 3'd0, 32'h0000_100C, 4'd4, 128'h0, 8'h06, 128'h01234567};
    vecs[6] = '{1'b0, 3'd0, 32'h0000_0000, 4'd0, 128'h0, 8'h07, LINE2};
    vecs[7] = '{1'b0, 3'd1, 32'h0000_0FF0, 4'd0, LINE3, 8'h08, 128'h0};
    vecs[8] = '{1'b1, 3'd0, 32'hABCD_FFF0, 4'd0, 128'h0, 8'h09, LINE3};
    vecs[9] = '{1'b0, 3'd0, 32'h0000_1000, 4'd4, 128'h0, 8'h0A, 128'h89ABCDEF};

    // Reset with both request valids high: nothing may be granted or returned.
    reset = 1'b1;
    imemresp_rdy = 1'b1;
    dmemresp_rdy = 1'b1;
    drive(1'b0, 1'b1, mk_req(3'd0, 32'h1000, 4'd0, 128'h0, 8'hEE));
    drive(1'b1, 1'b1, mk_req(3'd0, 32'h1000, 4'd0, 128'h0, 8'hEE));
    @(negedge clk);
    chk("rst_irdy", 128'(imemreq_rdy), 128'd0);
    chk("rst_drdy", 128'(dmemreq_rdy), 128'd0);
    chk("rst_ival", 128'(imemresp_val), 128'd0);
    chk("rst_dval", 128'(dmemresp_val), 128'd0);
    check_counters("rst");
    @(posedge clk); #1;
    imemreq_val = 1'b0;
    dmemreq_val = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_dval", c), 128'(dmemresp_val), 128'd0);
      chk($sformatf("idle%0d_drdy", c), 128'(dmemreq_rdy), 128'd0);
    end
    check_counters("idle");
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec($sformatf("v%0d", i), vecs[i]);
    check_counters("vec");

    // Both ports contend from reset: grants alternate starting with imem.
    pulse_reset();
    iop = 8'h10; dop = 8'h20;
    igr = '{1'b1, 1'b0, 1'b1, 1'b0};
    drive(1'b0, 1'b1, mk_req(3'd0, 32'h1000, 4'd0, 128'h0, iop));
    drive(1'b1, 1'b1, mk_req(3'd0, 32'h1000, 4'd0, 128'h0, dop));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 4) begin
        chk($sformatf("arb%0d_irdy", c), 128'(imemreq_rdy), 128'(igr[c]));
        chk($sformatf("arb%0d_drdy", c), 128'(dmemreq_rdy), 128'(!igr[c]));
      end
      if (imemresp_val) begin ilog.push_back(imemresp_msg.opaque); icyc.push_back(c); end
      if (dmemresp_val) begin dlog.push_back(dmemresp_msg.opaque); dcyc.push_back(c); end
      @(posedge clk); #1;
      if (c < 4) begin
        exp_reads++;
        if (igr[c]) begin iop++; drive(1'b0, 1'b1, mk_req(3'd0, 32'h1000, 4'd0, 128'h0, iop)); end
        else        begin dop++; drive(1'b1, 1'b1, mk_req(3'd0, 32'h1000, 4'd0, 128'h0, dop)); end
      end
      if (c == 3) begin imemreq_val = 1'b0; dmemreq_val = 1'b0; end
    end
    chk("arb_icount", 128'(ilog.size()), 128'd2);
    chk("arb_dcount", 128'(dlog.size()), 128'd2);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("arb_iopq%0d", k), 128'((ilog.size() > k) ? ilog[k] : 8'hFF), 128'(8'h10 + k));
      chk($sformatf("arb_icyc%0d", k), 128'((icyc.size() > k) ? icyc[k] : 99), 128'(2 + 2 * k));
      chk($sformatf("arb_dopq%0d", k), 128'((dlog.size() > k) ? dlog[k] : 8'hFF), 128'(8'h20 + k));
      chk($sformatf("arb_dcyc%0d", k), 128'((dcyc.size() > k) ? dcyc[k] : 99), 128'(3 + 2 * k));
    end

    // dmem response stall: credits run out after two accepts, imem keeps flowing.
    dmemresp_rdy = 1'b0;
    drive(1'b1, 1'b1, mk_req(3'd0, 32'h1000, 4'd0, 128'h0, 8'h30));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c <= 7) chk($sformatf("bp%0d_drdy", c), 128'(dmemreq_rdy), 128'((c <= 1 || c == 7) ? 1 : 0));
      if (c == 2) chk("bp2_irdy", 128'(imemreq_rdy), 128'd1);
      if (c == 4) begin
        chk("bp4_ival", 128'(imemresp_val), 128'd1);
        chk("bp4_iopq", 128'(imemresp_msg.opaque), 128'h40);
      end
      if (c == 2 || c == 5 || c == 6) begin
        chk($sformatf("bp%0d_dval", c), 128'(dmemresp_val), 128'd1);
        chk($sformatf("bp%0d_dopq", c), 128'(dmemresp_msg.opaque), 128'h30);
      end
      if (c == 7) begin
        chk("bp7_dval", 128'(dmemresp_val), 128'd1);
        chk("bp7_dopq", 128'(dmemresp_msg.opaque), 128'h31);
      end
      if (c == 8) chk("bp8_dval", 128'(dmemresp_val), 128'd0);
      if (c == 9) begin
        chk("bp9_dval", 128'(dmemresp_val), 128'd1);
        chk("bp9_dopq", 128'(dmemresp_msg.opaque), 128'h32);
      end
      @(posedge clk); #1;
      case (c)
        0: begin exp_reads++; drive(1'b1, 1'b1, mk_req(3'd0, 32'h1000, 4'd0, 128'h0, 8'h31)); end
        1: begin
          exp_reads++;
          drive(1'b1, 1'b1, mk_req(3'd0, 32'h1000, 4'd0, 128'h0, 8'h32));
          drive(1'b0, 1'b1, mk_req(3'd0, 32'h1000, 4'd0, 128'h0, 8'h40));
        end
        2: begin exp_reads++; imemreq_val = 1'b0; end
        5: dmemresp_rdy = 1'b1;
        7: begin exp_reads++; dmemreq_val = 1'b0; end
        default: ;
      endcase
    end
    check_counters("bp");

    // Reset one cycle after an imem read is accepted: its response must never appear.
    drive(1'b0, 1'b1, mk_req(3'd0, 32'h1000, 4'd0, 128'h0, 8'h50));
    @(negedge clk);
    chk("mid_irdy", 128'(imemreq_rdy), 128'd1);
    @(posedge clk); #1;
    imemreq_val = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ival", 128'(imemresp_val), 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_reads = 0;
    exp_writes = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("mid%0d_ival", c), 128'(imemresp_val), 128'd0);
    end
    @(posedge clk); #1;

    // Full credit count after reset: two accepts with the response side stalled, then blocked.
    imemresp_rdy = 1'b0;
    drive(1'b0, 1'b1, mk_req(3'd0, 32'h1000, 4'd0, 128'h0, 8'h60));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("cred%0d_irdy", c), 128'(imemreq_rdy), 128'((c < 2) ? 1 : 0));
      @(posedge clk); #1;
      if (c < 2) exp_reads++;
    end
    imemreq_val = 1'b0;
    imemresp_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    run_vec("post", '{1'b0, 3'd0, 32'h0000_1000, 4'd0, 128'h0, 8'h51, LINE2});
    check_counters("final");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
